// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter FSM encodings and load/store formats.
// Constants only; no logic, no latency, no flow control.
package uart_pkg;

   // Register offsets within the 16-byte window (bus_address[3:0])
   localparam logic [3:0] REG_TXDATA  = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_DIVISOR = 4'h8;
   localparam logic [3:0] REG_CTRL    = 4'hC;

   // STATUS bit positions
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 8;

   // Transmitter FSM encodings; the enum mirrors them for debug visibility
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } uart_tx_state_t;

   // Load/store formats: funct3 encoding as produced by the core
   localparam logic [2:0] FMT_B  = 3'b000;
   localparam logic [2:0] FMT_H  = 3'b001;
   localparam logic [2:0] FMT_W  = 3'b010;
   localparam logic [2:0] FMT_BU = 3'b100;
   localparam logic [2:0] FMT_HU = 3'b101;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and first-word fall-through read data.
// Latency: a push is visible (empty/count) one edge later; pop_data is combinational.
// Backpressure: push while full is dropped unless a pop happens on the same edge; pop while empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign pop_ok   = pop && !empty;
   // A full FIFO still takes a push when a pop frees the slot on the same edge
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   // Storage array; needs no reset since count gates every read
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, registers, TX FIFO, framing FSM.
// Latency: loads answer combinationally; a stored byte starts its frame one edge after the store commits.
// Backpressure: none on the bus; a byte pushed into a full FIFO is dropped and flags sticky overflow.
module mmio_uart_tx import uart_pkg::*; #(
   parameter logic [31:0] BASE_ADDRESS    = 32'h1000_0000,
   parameter int          FIFO_DEPTH      = 8,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [2:0]  bus_format,
   input  logic        bus_read_enable,
   input  logic        bus_write_enable,
   output logic [31:0] bus_data_fetched,
   output logic        selected,
   output logic        uart_tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0]   divisor;
   logic          enable;
   logic          overflow;
   logic [1:0]    state;
   logic [15:0]   timer;
   logic [15:0]   div_latched;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          tx_q;

   logic          wr_ok, wr_txdata, wr_status, wr_divisor, wr_ctrl;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_rd_data;
   logic          bit_end, frame_start;
   logic [31:0]   status_word, reg_word, shifted;
   logic [31:0]   formatted;
   logic          unused_bits;

   assign unused_bits = ^bus_write_data[31:16];

   // Decode: only word-aligned stores inside the window touch state
   assign selected   = (bus_address[31:4] == BASE_ADDRESS[31:4]);
   assign wr_ok      = selected && bus_write_enable && (bus_address[1:0] == 2'b00);
   assign wr_txdata  = wr_ok && (bus_address[3:0] == REG_TXDATA);
   assign wr_status  = wr_ok && (bus_address[3:0] == REG_STATUS);
   assign wr_divisor = wr_ok && (bus_address[3:0] == REG_DIVISOR);
   assign wr_ctrl    = wr_ok && (bus_address[3:0] == REG_CTRL);

   // A new frame begins from IDLE, or straight out of the last STOP cycle so frames abut
   assign bit_end     = (timer == 16'd0);
   assign frame_start = enable && !fifo_empty &&
                        ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
   assign fifo_pop    = frame_start;
   assign uart_tx     = tx_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_txdata),
      .push_data (bus_write_data[7:0]),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Software-visible registers: DIVISOR, CTRL.enable and sticky overflow
   always_ff @(posedge clock) begin
      if (reset) begin
         divisor  <= DEFAULT_DIVISOR;
         enable   <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_divisor) begin
            if (bus_format[1:0] == 2'b00) divisor[7:0] <= bus_write_data[7:0];
            else                          divisor      <= bus_write_data[15:0];
         end
         if (wr_ctrl) enable <= bus_write_data[0];
         if (wr_txdata && fifo_full && !fifo_pop)
            overflow <= 1'b1;
         else if (wr_status && bus_write_data[STAT_OVERFLOW])
            overflow <= 1'b0;
      end
   end

   // Framing FSM, bit timer and bit counter; the line is driven straight from tx_q
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         tx_q        <= 1'b1;
         timer       <= 16'd0;
         div_latched <= 16'd0;
         bit_cnt     <= 3'd0;
         shift       <= 8'd0;
      end else if (frame_start) begin
         state       <= ST_START;
         tx_q        <= 1'b0;
         shift       <= fifo_rd_data;
         div_latched <= divisor;
         timer       <= divisor;
      end else begin
         case (state)
            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  tx_q    <= shift[0];
                  shift   <= {1'b0, shift[7:1]};
                  bit_cnt <= 3'd0;
                  timer   <= div_latched;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  timer <= div_latched;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_STOP;
                     tx_q  <= 1'b1;
                  end else begin
                     tx_q    <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  state <= ST_IDLE;
                  tx_q  <= 1'b1;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

   // STATUS word assembly
   always_comb begin
      status_word                            = 32'd0;
      status_word[STAT_FULL]                 = fifo_full;
      status_word[STAT_EMPTY]                = fifo_empty;
      status_word[STAT_BUSY]                 = (state != ST_IDLE);
      status_word[STAT_OVERFLOW]             = overflow;
      status_word[STAT_COUNT_LSB +: 4]       = 4'(fifo_count);
   end

   // Load path: pick register word, align by byte offset, then slice and extend
   always_comb begin
      case (bus_address[3:2])
         2'd1:    reg_word = status_word;
         2'd2:    reg_word = {16'd0, divisor};
         2'd3:    reg_word = {31'd0, enable};
         default: reg_word = 32'd0;
      endcase
      shifted = reg_word >> {bus_address[1:0], 3'b000};
      case (bus_format)
         FMT_B:   formatted = {{24{shifted[7]}}, shifted[7:0]};
         FMT_H:   formatted = {{16{shifted[15]}}, shifted[15:0]};
         FMT_W:   formatted = shifted;
         FMT_BU:  formatted = {24'd0, shifted[7:0]};
         FMT_HU:  formatted = {16'd0, shifted[15:0]};
         default: formatted = 32'd0;
      endcase
      bus_data_fetched = (selected && bus_read_enable) ? formatted : 32'd0;
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register defaults, framing, back-to-back
// frames, overflow, load formatting, mid-frame reset and sub-word writes.
// Expected values are hand-derived constants and a small frame-bit model.
module tb_mmio_uart_tx;
   import uart_pkg::*;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] bus_address = 32'd0;
   logic [31:0] bus_write_data = 32'd0;
   logic [2:0]  bus_format = FMT_W;
   logic        bus_read_enable = 1'b0;
   logic        bus_write_enable = 1'b0;
   logic [31:0] bus_data_fetched;
   logic        selected;
   logic        uart_tx;

   int n_checks = 0;
   int n_errors = 0;

   logic tx_log   [0:127];
   logic busy_log [0:127];

   always #5 clock = ~clock;

   mmio_uart_tx #(
      .BASE_ADDRESS    (BASE),
      .FIFO_DEPTH      (8),
      .DEFAULT_DIVISOR (16'd433)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .bus_address      (bus_address),
      .bus_write_data   (bus_write_data),
      .bus_format       (bus_format),
      .bus_read_enable  (bus_read_enable),
      .bus_write_enable (bus_write_enable),
      .bus_data_fetched (bus_data_fetched),
      .selected         (selected),
      .uart_tx          (uart_tx)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected line level for bit slot k of a frame carrying byte b
   function automatic logic fbit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] fmt);
      @(negedge clock);
      bus_address      = addr;
      bus_write_data   = data;
      bus_format       = fmt;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b1;
      @(negedge clock);
      bus_write_enable = 1'b0;
   endtask

   task automatic peek(input logic [31:0] addr, input logic [2:0] fmt,
                       output logic [31:0] data, output logic sel);
      bus_address      = addr;
      bus_format       = fmt;
      bus_write_enable = 1'b0;
      bus_read_enable  = 1'b1;
      #1;
      data = bus_data_fetched;
      sel  = selected;
      bus_read_enable = 1'b0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [2:0] fmt,
                       output logic [31:0] data, output logic sel);
      @(negedge clock);
      peek(addr, fmt, data, sel);
   endtask

   // Log uart_tx and STATUS.busy once per cycle, mid-cycle
   task automatic sample_stream(input int n);
      bus_address     = BASE + 32'h4;
      bus_format      = FMT_W;
      bus_read_enable = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         #1;
         tx_log[i]   = uart_tx;
         busy_log[i] = bus_data_fetched[STAT_BUSY];
      end
      bus_read_enable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        sel;
      logic [63:0] got_v, exp_v;
      logic [9:0]  frm;
      int          cnt, cnt80;

      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset defaults
      load(BASE + 32'h4, FMT_W, rd, sel);
      check("rst_status", rd, 32'h0000_0002);
      load(BASE + 32'h8, FMT_W, rd, sel);
      check("rst_divisor", rd, 32'd433);
      load(BASE + 32'hC, FMT_W, rd, sel);
      check("rst_ctrl", rd, 32'd1);
      check("rst_tx", uart_tx, 1'b1);

      // Single frame, DIVISOR=3
      store(BASE + 32'h8, 32'd3, FMT_W);
      store(BASE + 32'h0, 32'hA5, FMT_W);
      sample_stream(44);
      got_v = '0; exp_v = '0;
      for (int i = 0; i < 40; i++) begin
         got_v[i] = tx_log[i];
         exp_v[i] = fbit(8'hA5, i / 4);
      end
      check("a5_line", got_v, exp_v);
      got_v = '0;
      for (int i = 0; i < 44; i++) got_v[i] = busy_log[i];
      check("a5_busy_40", got_v, 64'h0000_00FF_FFFF_FFFF);
      check("a5_idle_after", {tx_log[40], tx_log[41], tx_log[42], tx_log[43]}, 4'hF);

      // Back-to-back frames and overflow
      store(BASE + 32'h8, 32'd0, FMT_W);
      store(BASE + 32'hC, 32'd0, FMT_W);
      store(BASE + 32'h0, 32'h30, FMT_W);
      peek(BASE + 32'h4, FMT_W, rd, sel);
      check("status_after_push", rd, 32'h0000_0100);
      for (int i = 1; i < 9; i++) store(BASE, 32'h30 + i, FMT_W);
      load(BASE + 32'h4, FMT_W, rd, sel);
      check("overflow_status", rd, 32'h0000_0809);
      store(BASE + 32'h4, 32'h8, FMT_W);
      load(BASE + 32'h4, FMT_W, rd, sel);
      check("overflow_clear", rd, 32'h0000_0801);
      store(BASE + 32'hC, 32'd1, FMT_W);
      sample_stream(90);
      cnt = 0; cnt80 = 0;
      for (int i = 0; i < 90; i++) begin
         if (busy_log[i]) cnt++;
         if (busy_log[i] && i < 80) cnt80++;
      end
      check("b2b_busy_first80", cnt80, 80);
      check("b2b_busy_after", cnt - cnt80, 0);
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 10; j++) frm[j] = tx_log[10*k + j];
         check($sformatf("b2b_frame%0d", k), frm, {1'b1, 8'(8'h30 + k), 1'b0});
      end
      load(BASE + 32'h4, FMT_W, rd, sel);
      check("b2b_empty_end", rd, 32'h0000_0002);

      // Load formatting
      store(BASE + 32'h8, 32'h80F0, FMT_W);
      load(BASE + 32'h8, FMT_B, rd, sel);
      check("lb_8", rd, 32'hFFFF_FFF0);
      check("sel_in_window", sel, 1'b1);
      load(BASE + 32'h9, FMT_BU, rd, sel);
      check("lbu_9", rd, 32'h0000_0080);
      load(BASE + 32'h9, FMT_B, rd, sel);
      check("lb_9", rd, 32'hFFFF_FF80);
      load(BASE + 32'h8, FMT_H, rd, sel);
      check("lh_8", rd, 32'hFFFF_80F0);
      load(BASE + 32'h8, FMT_HU, rd, sel);
      check("lhu_8", rd, 32'h0000_80F0);
      load(BASE + 32'h0, FMT_W, rd, sel);
      check("txdata_reads_0", rd, 32'd0);
      load(32'h2000_0008, FMT_W, rd, sel);
      check("outside_data", rd, 32'd0);
      check("outside_sel", sel, 1'b0);

      // Reset mid-frame
      store(BASE + 32'h8, 32'd3, FMT_W);
      store(BASE, 32'h11, FMT_W);
      store(BASE, 32'h22, FMT_W);
      store(BASE, 32'h33, FMT_W);
      repeat (6) @(negedge clock);
      load(BASE + 32'h4, FMT_W, rd, sel);
      check("pre_reset_status", rd, 32'h0000_0204);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      peek(BASE + 32'h4, FMT_W, rd, sel);
      check("post_reset_tx", uart_tx, 1'b1);
      check("post_reset_status", rd, 32'h0000_0002);
      load(BASE + 32'h8, FMT_W, rd, sel);
      check("post_reset_divisor", rd, 32'd433);
      sample_stream(60);
      cnt = 0;
      for (int i = 0; i < 60; i++) if (!tx_log[i] || busy_log[i]) cnt++;
      check("post_reset_quiet", cnt, 0);

      // Misaligned and sub-word writes
      store(BASE + 32'h8, 32'h1234, FMT_W);
      store(BASE + 32'h9, 32'hFFFF_FFFF, FMT_W);
      load(BASE + 32'h8, FMT_W, rd, sel);
      check("misaligned_ignored", rd, 32'h0000_1234);
      store(BASE + 32'h8, 32'h7, FMT_B);
      load(BASE + 32'h8, FMT_W, rd, sel);
      check("sb_divisor", rd, 32'h0000_1207);
      store(BASE + 32'h8, 32'h1234_BEEF, FMT_H);
      load(BASE + 32'h8, FMT_W, rd, sel);
      check("sh_divisor", rd, 32'h0000_BEEF);
      store(BASE + 32'h8, 32'd0, FMT_W);
      store(BASE, 32'h1FF, FMT_W);
      sample_stream(12);
      for (int j = 0; j < 10; j++) frm[j] = tx_log[j];
      check("txdata_1ff_frame", frm, {1'b1, 8'hFF, 1'b0});
      check("txdata_1ff_done", {tx_log[10], busy_log[10]}, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
